// File: rtl/epu_defs.sv
// Shared decode definitions for the EPU pipeline: opcodes, the issue-type
// enumeration seen by EX, and the decode output-register states.
package epu_defs;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    NOP     = 4'd0,
    ALU     = 4'd1,
    ALUI    = 4'd2,
    LOAD    = 4'd3,
    STORE   = 4'd4,
    BRANCH  = 4'd5,
    JAL     = 4'd6,
    JALR    = 4'd7,
    LUI     = 4'd8,
    AUIPC   = 4'd9,
    ILLEGAL = 4'd10
  } ex_type_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } id_state_e;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects the I/S/B/U/J immediate layout from the opcode
// and sign-extends to 32 bits; formats without an immediate yield zero.
module imm_gen
  import epu_defs::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  logic [6:0] opcode;

  assign opcode = inst[6:0];

  always_comb begin
    imm = ZeroWord;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {inst[31:12], 12'h000};
      OPC_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = ZeroWord;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: decodes the fetched instruction, resolves operands through
// EX/MEM forwarding, stalls on hazards and holds the result in one output register.
module id_stage
  import epu_defs::*;
#(
  parameter int FWD_EN = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        id_ready,
  output logic        read_flag_1,
  output logic        read_flag_2,
  output logic [4:0]  reg_read_1,
  output logic [4:0]  reg_read_2,
  input  logic [31:0] output_data_1,
  input  logic [31:0] output_data_2,
  input  logic        ex_fwd_we,
  input  logic [4:0]  ex_fwd_rd,
  input  logic [31:0] ex_fwd_data,
  input  logic        ex_fwd_load,
  input  logic        mem_fwd_we,
  input  logic [4:0]  mem_fwd_rd,
  input  logic [31:0] mem_fwd_data,
  input  logic        flush_in,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [3:0]  ex_type,
  output logic [3:0]  ex_funct,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic        ex_rd_we
);

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  ex_type_e    dec_type;
  logic        use_rs1, use_rs2, has_rd;
  logic [31:0] dec_imm;
  logic [31:0] op1_val, op2_val;
  logic        ex_hit, mem_hit;
  logic        ex_match_1, ex_match_2, mem_match_1, mem_match_2;
  logic        load_use, nofwd_hazard, hazard, accept;

  id_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ex_type_e    type_q, type_d;
  logic [3:0]  funct_q, funct_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_we_q, rd_we_d;

  assign opcode = if_inst[6:0];
  assign rd     = if_inst[11:7];
  assign rs1    = if_inst[19:15];
  assign rs2    = if_inst[24:20];

  always_comb begin
    dec_type = ILLEGAL;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    has_rd   = 1'b0;
    case (opcode)
      OPC_OP:     begin dec_type = ALU;    use_rs1 = 1'b1; use_rs2 = 1'b1; has_rd = 1'b1; end
      OPC_OP_IMM: begin dec_type = ALUI;   use_rs1 = 1'b1; has_rd = 1'b1; end
      OPC_LOAD:   begin dec_type = LOAD;   use_rs1 = 1'b1; has_rd = 1'b1; end
      OPC_STORE:  begin dec_type = STORE;  use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_BRANCH: begin dec_type = BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_JAL:    begin dec_type = JAL;    has_rd = 1'b1; end
      OPC_JALR:   begin dec_type = JALR;   use_rs1 = 1'b1; has_rd = 1'b1; end
      OPC_LUI:    begin dec_type = LUI;    has_rd = 1'b1; end
      OPC_AUIPC:  begin dec_type = AUIPC;  has_rd = 1'b1; end
      default:    dec_type = ILLEGAL;
    endcase
  end

  assign read_flag_1 = use_rs1;
  assign read_flag_2 = use_rs2;
  assign reg_read_1  = rs1;
  assign reg_read_2  = rs2;

  imm_gen u_imm_gen (
    .inst (if_inst),
    .imm  (dec_imm)
  );

  assign ex_hit      = ex_fwd_we && (ex_fwd_rd != 5'd0);
  assign mem_hit     = mem_fwd_we && (mem_fwd_rd != 5'd0);
  assign ex_match_1  = ex_hit && (ex_fwd_rd == rs1);
  assign ex_match_2  = ex_hit && (ex_fwd_rd == rs2);
  assign mem_match_1 = mem_hit && (mem_fwd_rd == rs1);
  assign mem_match_2 = mem_hit && (mem_fwd_rd == rs2);

  // A load in EX has no data yet, so it must never be the forwarding source.
  always_comb begin
    op1_val = output_data_1;
    if (rs1 == 5'd0)                      op1_val = ZeroWord;
    else if (ex_match_1 && !ex_fwd_load)  op1_val = ex_fwd_data;
    else if (mem_match_1)                 op1_val = mem_fwd_data;
    op2_val = output_data_2;
    if (rs2 == 5'd0)                      op2_val = ZeroWord;
    else if (ex_match_2 && !ex_fwd_load)  op2_val = ex_fwd_data;
    else if (mem_match_2)                 op2_val = mem_fwd_data;
  end

  assign load_use     = ex_fwd_load && ((use_rs1 && ex_match_1) || (use_rs2 && ex_match_2));
  assign nofwd_hazard = (use_rs1 && (ex_match_1 || mem_match_1)) ||
                        (use_rs2 && (ex_match_2 || mem_match_2));
  assign hazard       = load_use || ((FWD_EN == 0) && nofwd_hazard);

  assign ex_valid = (state_q == ST_FULL);
  assign id_ready = rst_in && rdy_in && !hazard && !flush_in && (!ex_valid || ex_ready);
  assign accept   = if_valid && id_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    type_d  = type_q;
    funct_d = funct_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    rd_we_d = rd_we_q;
    if (rdy_in) begin
      if (flush_in) begin
        state_d = ST_EMPTY;
      end else if (accept) begin
        state_d = ST_FULL;
        pc_d    = if_pc;
        type_d  = dec_type;
        funct_d = {if_inst[30], if_inst[14:12]};
        op1_d   = use_rs1 ? op1_val : ZeroWord;
        op2_d   = use_rs2 ? op2_val : ZeroWord;
        imm_d   = dec_imm;
        rd_d    = rd;
        rd_we_d = has_rd && (rd != 5'd0);
      end else if ((state_q == ST_FULL) && ex_ready) begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_EMPTY;
      pc_q    <= ZeroWord;
      type_q  <= NOP;
      funct_q <= 4'd0;
      op1_q   <= ZeroWord;
      op2_q   <= ZeroWord;
      imm_q   <= ZeroWord;
      rd_q    <= 5'd0;
      rd_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      type_q  <= type_d;
      funct_q <= funct_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      rd_we_q <= rd_we_d;
    end
  end

  assign ex_pc    = pc_q;
  assign ex_type  = type_q;
  assign ex_funct = funct_q;
  assign ex_op1   = op1_q;
  assign ex_op2   = op2_q;
  assign ex_imm   = imm_q;
  assign ex_rd    = rd_q;
  assign ex_rd_we = rd_we_q;

endmodule
